// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm-clock keypad sequencer.
package clock_pkg;

  localparam int DIGIT_W             = 4;
  localparam int TIMEOUT_SEC_DEFAULT = 10;

  localparam logic [DIGIT_W-1:0] KEY_AMPM   = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_CANCEL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_KEY_ENTRY  = 3'd1,
    ST_SHOW_ALARM = 3'd2,
    ST_LOAD_TIME  = 3'd3,
    ST_LOAD_ALARM = 3'd4
  } state_e;

  // Operation applied to the entry buffer on the next clock edge.
  typedef enum logic [2:0] {
    BUF_HOLD   = 3'd0,
    BUF_CLEAR  = 3'd1,
    BUF_FIRST  = 3'd2,
    BUF_SHIFT  = 3'd3,
    BUF_TOGGLE = 3'd4
  } buf_op_e;

endpackage

// File: rtl/clock_key_buffer.sv
// Entry buffer: four BCD digits plus AM flag, with a combinational
// validity flag for the hh:mm value currently held.
module clock_key_buffer
  import clock_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  buf_op_e            op,
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] ls_min,
  output logic [DIGIT_W-1:0] ms_min,
  output logic [DIGIT_W-1:0] ls_hr,
  output logic [DIGIT_W-1:0] ms_hr,
  output logic               am,
  output logic               valid
);

  logic [DIGIT_W-1:0] ls_min_q, ls_min_d;
  logic [DIGIT_W-1:0] ms_min_q, ms_min_d;
  logic [DIGIT_W-1:0] ls_hr_q,  ls_hr_d;
  logic [DIGIT_W-1:0] ms_hr_q,  ms_hr_d;
  logic               am_q,     am_d;
  logic [7:0]         hour;

  // Buffer next value: first digit restarts the entry, later digits shift in.
  always_comb begin
    ls_min_d = ls_min_q;
    ms_min_d = ms_min_q;
    ls_hr_d  = ls_hr_q;
    ms_hr_d  = ms_hr_q;
    am_d     = am_q;
    case (op)
      BUF_CLEAR: begin
        ls_min_d = '0;
        ms_min_d = '0;
        ls_hr_d  = '0;
        ms_hr_d  = '0;
        am_d     = 1'b0;
      end
      BUF_FIRST: begin
        ls_min_d = digit;
        ms_min_d = '0;
        ls_hr_d  = '0;
        ms_hr_d  = '0;
        am_d     = 1'b0;
      end
      BUF_SHIFT: begin
        ms_hr_d  = ls_hr_q;
        ls_hr_d  = ms_min_q;
        ms_min_d = ls_min_q;
        ls_min_d = digit;
      end
      BUF_TOGGLE: am_d = ~am_q;
      default: ;
    endcase
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ls_min_q <= '0;
      ms_min_q <= '0;
      ls_hr_q  <= '0;
      ms_hr_q  <= '0;
      am_q     <= 1'b0;
    end else begin
      ls_min_q <= ls_min_d;
      ms_min_q <= ms_min_d;
      ls_hr_q  <= ls_hr_d;
      ms_hr_q  <= ms_hr_d;
      am_q     <= am_d;
    end
  end

  // Entry is a legal 12-hour time: hour 01..12, minutes 00..59.
  always_comb begin
    hour  = 8'(ms_hr_q) * 8'd10 + 8'(ls_hr_q);
    valid = (ms_hr_q <= 4'd1) && (ls_hr_q <= 4'd9) &&
            (hour >= 8'd1) && (hour <= 8'd12) &&
            (ms_min_q <= 4'd5) && (ls_min_q <= 4'd9);
  end

  assign ls_min = ls_min_q;
  assign ms_min = ms_min_q;
  assign ls_hr  = ls_hr_q;
  assign ms_hr  = ms_hr_q;
  assign am     = am_q;

endmodule

// File: rtl/clock_key_fsm.sv
// Keypad/button sequencer for the alarm clock. Collects digits into the
// entry buffer, validates them and issues one-cycle load strobes.
// Optional build macro KEY_TIMEOUT_EN: abandon an entry after TIMEOUT_SEC
// one_second ticks without a key.
//
// state          | meaning
// ---------------+-------------------------------------------------
// ST_IDLE        | waiting for a first digit or the alarm button
// ST_KEY_ENTRY   | collecting digits / AM toggle, entry displayed
// ST_SHOW_ALARM  | alarm time displayed while alarm_button is held
// ST_LOAD_TIME   | load_new_c strobe (one cycle)
// ST_LOAD_ALARM  | load_new_a strobe (one cycle), then show alarm
module clock_key_fsm
  import clock_pkg::*;
#(
  parameter int TIMEOUT_SEC = TIMEOUT_SEC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DIGIT_W-1:0] key,
  input  logic               key_valid,
  input  logic               time_button,
  input  logic               alarm_button,
  input  logic               one_second,
  output logic [DIGIT_W-1:0] new_time_ls_min,
  output logic [DIGIT_W-1:0] new_time_ms_min,
  output logic [DIGIT_W-1:0] new_time_ls_hr,
  output logic [DIGIT_W-1:0] new_time_ms_hr,
  output logic               new_time_AM,
  output logic               show_new_time,
  output logic               show_a,
  output logic               load_new_c,
  output logic               load_new_a,
  output logic               load_err
);

  state_e  state_q, state_d;
  buf_op_e buf_op;
  logic    load_err_q, load_err_d;
  logic    buf_valid;
  logic    key_is_digit;
  logic    timeout_hit;

  assign key_is_digit = (key <= 4'd9);

  clock_key_buffer u_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .op      (buf_op),
    .digit   (key),
    .ls_min  (new_time_ls_min),
    .ms_min  (new_time_ms_min),
    .ls_hr   (new_time_ls_hr),
    .ms_hr   (new_time_ms_hr),
    .am      (new_time_AM),
    .valid   (buf_valid)
  );

`ifdef KEY_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_SEC + 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             key_restart;

  // Any key that lands in the buffer restarts the inactivity window.
  assign key_restart = (buf_op == BUF_FIRST) || (buf_op == BUF_SHIFT) ||
                       (buf_op == BUF_TOGGLE);

  // Terminal count is the tick that would take the counter from 1 to 0.
  assign timeout_hit = (state_q == ST_KEY_ENTRY) && one_second &&
                       (timer_q == TMR_W'(1));

  // Inactivity down-counter, decremented by one_second while entering.
  always_comb begin
    timer_d = timer_q;
    if (key_restart)
      timer_d = TMR_W'(TIMEOUT_SEC);
    else if ((state_q == ST_KEY_ENTRY) && one_second && (timer_q != '0))
      timer_d = timer_q - TMR_W'(1);
  end

  // Inactivity counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timer_q <= '0;
    else          timer_q <= timer_d;
  end
`else
  logic unused_one_second;
  localparam int unused_timeout_sec = TIMEOUT_SEC;

  assign unused_one_second = one_second;
  assign timeout_hit       = 1'b0;
`endif

  // State and error-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_err_q <= load_err_d;
    end
  end

  // Next state and buffer operation; priority time > alarm > key > timeout.
  always_comb begin
    state_d    = state_q;
    buf_op     = BUF_HOLD;
    load_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (alarm_button) begin
          state_d = ST_SHOW_ALARM;
        end else if (key_valid && key_is_digit) begin
          state_d = ST_KEY_ENTRY;
          buf_op  = BUF_FIRST;
        end
      end
      ST_KEY_ENTRY: begin
        if (time_button) begin
          if (buf_valid) begin
            state_d = ST_LOAD_TIME;
          end else begin
            state_d    = ST_IDLE;
            load_err_d = 1'b1;
          end
        end else if (alarm_button) begin
          if (buf_valid) begin
            state_d = ST_LOAD_ALARM;
          end else begin
            state_d    = ST_IDLE;
            load_err_d = 1'b1;
          end
        end else if (key_valid) begin
          if (key_is_digit) begin
            buf_op = BUF_SHIFT;
          end else if (key == KEY_AMPM) begin
            buf_op = BUF_TOGGLE;
          end else if (key == KEY_CANCEL) begin
            buf_op  = BUF_CLEAR;
            state_d = ST_IDLE;
          end
        end else if (timeout_hit) begin
          buf_op  = BUF_CLEAR;
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_TIME:  state_d = ST_IDLE;
      // Land in SHOW_ALARM so a still-held button does not re-commit.
      ST_LOAD_ALARM: state_d = ST_SHOW_ALARM;
      ST_SHOW_ALARM: begin
        if (!alarm_button) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    show_new_time = (state_q == ST_KEY_ENTRY) || (state_q == ST_LOAD_TIME) ||
                    (state_q == ST_LOAD_ALARM);
    show_a        = (state_q == ST_SHOW_ALARM);
    load_new_c    = (state_q == ST_LOAD_TIME);
    load_new_a    = (state_q == ST_LOAD_ALARM);
    load_err      = load_err_q;
  end

endmodule

// File: tb/tb_clock_key_fsm.sv
// Self-checking bench for clock_key_fsm. Load/error strobes are checked by a
// scoreboard; display and buffer behaviour by inline checks in each task.
module tb_clock_key_fsm;
  import clock_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key = 4'd0;
  logic       key_valid = 1'b0;
  logic       time_button = 1'b0;
  logic       alarm_button = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] new_time_ls_min, new_time_ms_min, new_time_ls_hr, new_time_ms_hr;
  logic       new_time_AM, show_new_time, show_a;
  logic       load_new_c, load_new_a, load_err;

  int checks = 0;
  int errors = 0;

  // kind: 0 load_new_c, 1 load_new_a, 2 load_err
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] buf_v;
    logic        am;
  } exp_t;
  exp_t sb[$];

  // Bench model of the entry buffer {ms_hr, ls_hr, ms_min, ls_min}.
  logic [15:0] m_buf = 16'h0;
  logic        m_am = 1'b0;
  logic        in_entry = 1'b0;

  always #5 clk = ~clk;

  clock_key_fsm #(.TIMEOUT_SEC(10)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .key             (key),
    .key_valid       (key_valid),
    .time_button     (time_button),
    .alarm_button    (alarm_button),
    .one_second      (one_second),
    .new_time_ls_min (new_time_ls_min),
    .new_time_ms_min (new_time_ms_min),
    .new_time_ls_hr  (new_time_ls_hr),
    .new_time_ms_hr  (new_time_ms_hr),
    .new_time_AM     (new_time_AM),
    .show_new_time   (show_new_time),
    .show_a          (show_a),
    .load_new_c      (load_new_c),
    .load_new_a      (load_new_a),
    .load_err        (load_err)
  );

  wire [15:0] dut_buf = {new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min};

  function automatic logic model_valid();
    int ms, ls, hr;
    ms = int'(m_buf[15:12]);
    ls = int'(m_buf[11:8]);
    hr = ms * 10 + ls;
    return (ms <= 1) && (ls <= 9) && (hr >= 1) && (hr <= 12) &&
           (m_buf[7:4] <= 4'd5) && (m_buf[3:0] <= 4'd9);
  endfunction

  // Scoreboard consumer: every strobe cycle must match the next expectation.
  always @(negedge clk) begin
    if (reset_n && (load_new_c || load_new_a || load_err)) begin
      logic [1:0] obs_kind;
      exp_t e;
      obs_kind = (load_new_c && !load_new_a && !load_err) ? 2'd0 :
                 (load_new_a && !load_new_c && !load_err) ? 2'd1 :
                 (load_err && !load_new_c && !load_new_a) ? 2'd2 : 2'd3;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_strobe: got kind %0d, expected no strobe", obs_kind);
      end else begin
        e = sb.pop_front();
        if (obs_kind !== e.kind) begin
          errors++;
          $display("FAIL sb_kind: got %0d, expected %0d", obs_kind, e.kind);
        end
        checks++;
        if (dut_buf !== e.buf_v || new_time_AM !== e.am) begin
          errors++;
          $display("FAIL sb_buffer: got %h/%b, expected %h/%b", dut_buf, new_time_AM, e.buf_v, e.am);
        end
      end
    end
  end

  task automatic press(input logic [3:0] k);
    key = k; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; key = 4'd0;
    if (in_entry) begin
      if (k <= 4'd9) m_buf = {m_buf[11:0], k};
      else if (k == 4'hA) m_am = ~m_am;
      else if (k == 4'hF) begin m_buf = 16'h0; m_am = 1'b0; in_entry = 1'b0; end
    end else if (k <= 4'd9) begin
      m_buf = {12'h0, k}; m_am = 1'b0; in_entry = 1'b1;
    end
  endtask

  task automatic commit_time();
    logic ok;
    ok = model_valid();
    sb.push_back('{kind: (ok ? 2'd0 : 2'd2), buf_v: m_buf, am: m_am});
    time_button = 1'b1;
    @(posedge clk); #1;
    time_button = 1'b0;
    in_entry = 1'b0;
    checks++;
    if (load_new_c !== ok) begin
      errors++; $display("FAIL commit_load_c: got %b, expected %b", load_new_c, ok);
    end
    checks++;
    if (load_err !== !ok) begin
      errors++; $display("FAIL commit_load_err: got %b, expected %b", load_err, !ok);
    end
    @(posedge clk); #1;
    checks++;
    if (load_new_c !== 1'b0 || load_err !== 1'b0 || show_new_time !== 1'b0) begin
      errors++;
      $display("FAIL commit_after: got c=%b err=%b show=%b, expected 0 0 0", load_new_c, load_err, show_new_time);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    m_buf = 16'h0; m_am = 1'b0; in_entry = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_buf !== 16'h0 || new_time_AM !== 1'b0) begin
      errors++; $display("FAIL reset_buffer: got %h/%b, expected 0000/0", dut_buf, new_time_AM);
    end
    checks++;
    if ({show_new_time, show_a, load_new_c, load_new_a, load_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00000", {show_new_time, show_a, load_new_c, load_new_a, load_err});
    end
  endtask

  task automatic test_idle_ignored();
    time_button = 1'b1; @(posedge clk); #1; time_button = 1'b0;
    press(4'hA);
    press(4'hF);
    @(posedge clk); #1;
    checks++;
    if (show_new_time !== 1'b0 || dut_buf !== 16'h0 || new_time_AM !== 1'b0) begin
      errors++; $display("FAIL idle_ignored: got show=%b buf=%h am=%b, expected 0 0000 0", show_new_time, dut_buf, new_time_AM);
    end
  endtask

  task automatic test_time_load();
    press(4'd1);
    checks++;
    if (show_new_time !== 1'b1 || dut_buf !== 16'h0001) begin
      errors++; $display("FAIL first_digit: got show=%b buf=%h, expected 1 0001", show_new_time, dut_buf);
    end
    press(4'd1); press(4'd3); press(4'd0);
    checks++;
    if (dut_buf !== 16'h1130 || dut_buf !== m_buf) begin
      errors++; $display("FAIL time_entry_buffer: got %h, expected 1130", dut_buf);
    end
    commit_time();
  endtask

  task automatic test_alarm_load();
    press(4'd7); press(4'd4); press(4'd5); press(4'hA);
    checks++;
    if (dut_buf !== 16'h0745 || new_time_AM !== 1'b1) begin
      errors++; $display("FAIL alarm_entry_buffer: got %h/%b, expected 0745/1", dut_buf, new_time_AM);
    end
    sb.push_back('{kind: 2'd1, buf_v: m_buf, am: m_am});
    alarm_button = 1'b1;
    @(posedge clk); #1;
    in_entry = 1'b0;
    checks++;
    if (load_new_a !== 1'b1 || load_new_c !== 1'b0) begin
      errors++; $display("FAIL alarm_strobe: got a=%b c=%b, expected 1 0", load_new_a, load_new_c);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (show_a !== 1'b1 || load_new_a !== 1'b0) begin
        errors++; $display("FAIL show_alarm_held: cycle %0d got show_a=%b a=%b, expected 1 0", i, show_a, load_new_a);
      end
    end
    alarm_button = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (show_a !== 1'b0) begin
      errors++; $display("FAIL show_alarm_release: got %b, expected 0", show_a);
    end
  endtask

  task automatic test_reject();
    press(4'd1); press(4'd3); press(4'd0); press(4'd0);
    commit_time();
  endtask

  task automatic test_cancel();
    press(4'd5); press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++;
    if (dut_buf !== 16'h1234) begin
      errors++; $display("FAIL shift_oldest_lost: got %h, expected 1234", dut_buf);
    end
    press(4'hF);
    checks++;
    if (dut_buf !== 16'h0 || new_time_AM !== 1'b0 || show_new_time !== 1'b0) begin
      errors++; $display("FAIL cancel: got buf=%h am=%b show=%b, expected 0000 0 0", dut_buf, new_time_AM, show_new_time);
    end
  endtask

  task automatic test_back_to_back();
    press(4'd1); press(4'd2); press(4'd0); press(4'd0);
    key = 4'd5; key_valid = 1'b1;
    commit_time();
    key_valid = 1'b0; key = 4'd0;
    checks++;
    if (dut_buf !== 16'h1200) begin
      errors++; $display("FAIL commit_over_key: got %h, expected 1200", dut_buf);
    end
  endtask

  task automatic test_timeout();
    press(4'd3);
    for (int i = 0; i < 9; i++) begin
      one_second = 1'b1; @(posedge clk); #1; one_second = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (show_new_time !== 1'b1 || dut_buf !== 16'h0003) begin
      errors++; $display("FAIL timeout_early: got show=%b buf=%h, expected 1 0003", show_new_time, dut_buf);
    end
`ifdef KEY_TIMEOUT_EN
    one_second = 1'b1; @(posedge clk); #1; one_second = 1'b0;
    m_buf = 16'h0; m_am = 1'b0; in_entry = 1'b0;
    checks++;
    if (show_new_time !== 1'b0 || dut_buf !== 16'h0) begin
      errors++; $display("FAIL timeout_expire: got show=%b buf=%h, expected 0 0000", show_new_time, dut_buf);
    end
`else
    for (int i = 0; i < 11; i++) begin
      one_second = 1'b1; @(posedge clk); #1; one_second = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (show_new_time !== 1'b1 || dut_buf !== 16'h0003) begin
      errors++; $display("FAIL no_timeout: got show=%b buf=%h, expected 1 0003", show_new_time, dut_buf);
    end
    press(4'hF);
`endif
  endtask

  task automatic test_reset_mid_load();
    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    time_button = 1'b1;
    @(posedge clk); #1;
    time_button = 1'b0;
    checks++;
    if (load_new_c !== 1'b1) begin
      errors++; $display("FAIL pre_reset_load: got %b, expected 1", load_new_c);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (load_new_c !== 1'b0 || show_new_time !== 1'b0 || dut_buf !== 16'h0) begin
      errors++; $display("FAIL reset_abort: got c=%b show=%b buf=%h, expected 0 0 0000", load_new_c, show_new_time, dut_buf);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_buf = 16'h0; m_am = 1'b0; in_entry = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (load_new_c !== 1'b0 || show_new_time !== 1'b0) begin
      errors++; $display("FAIL post_reset: got c=%b show=%b, expected 0 0", load_new_c, show_new_time);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignored();
    test_time_load();
    test_alarm_load();
    test_reject();
    test_cancel();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
